// File: rtl/chirp_sequencer_pkg.sv
// Shared definitions for the chirp profile sequencer: state encoding and profile
// record field widths.
package chirp_sequencer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_PRIME = 2'd2;
    localparam logic [1:0] ST_RUN   = 2'd3;

    typedef enum logic [1:0] {
        StIdle  = ST_IDLE,
        StLoad  = ST_LOAD,
        StPrime = ST_PRIME,
        StRun   = ST_RUN
    } state_t;

    localparam int unsigned CTRL_W  = 32;
    localparam int unsigned DELAY_W = 4;

    // Record layout: {min, max, inc, div, delay, down, reps, last}
    function automatic int unsigned prof_width(input int unsigned rpt_w);
        return 4 * CTRL_W + DELAY_W + 1 + rpt_w + 1;
    endfunction

endpackage

// File: rtl/chirp_profile_ram.sv
// Profile slot register file: one synchronous write port, one asynchronous read port.
module chirp_profile_ram #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3,
    parameter int unsigned W     = 142
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/chirp_sequencer.sv
// Plays stored chirp profiles in order, configuring and resetting the Chirp engine and
// counting sweep completions observed on its NCO control word.
module chirp_sequencer
    import chirp_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3,
    parameter int unsigned RPT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [31:0]        cfg_min,
    input  logic [31:0]        cfg_max,
    input  logic [31:0]        cfg_inc,
    input  logic [31:0]        cfg_div,
    input  logic [3:0]         cfg_delay,
    input  logic               cfg_down,
    input  logic [RPT_W-1:0]   cfg_reps,
    input  logic               cfg_last,
    input  logic               start,
    input  logic               stop,
    input  logic               loop_en,
    input  logic [31:0]        nco_ctrl,
    output logic               chirp_rst,
    output logic [31:0]        min_ctrl,
    output logic [31:0]        max_ctrl,
    output logic [31:0]        inc_rate,
    output logic [31:0]        div_rate,
    output logic [3:0]         delay,
    output logic               is_down,
    output logic               busy,
    output logic               done,
    output logic [AW-1:0]      cur_idx
);

    localparam int unsigned PW = prof_width(RPT_W);

    state_t             state;
    logic [RPT_W-1:0]   rep_cnt;
    logic [RPT_W-1:0]   reps_q;
    logic               last_q;

    logic [PW-1:0]      wdata;
    logic [PW-1:0]      rdata;
    logic [AW-1:0]      rd_idx;

    logic [31:0]        r_min, r_max, r_inc, r_div;
    logic [3:0]         r_delay;
    logic               r_down;
    logic [RPT_W-1:0]   r_reps;
    logic               r_last;

    logic               slot_last;
    logic               end_evt;
    logic [RPT_W-1:0]   reps_eff;
    logic               rep_hit;

    assign wdata = {cfg_min, cfg_max, cfg_inc, cfg_div, cfg_delay, cfg_down, cfg_reps, cfg_last};
    assign {r_min, r_max, r_inc, r_div, r_delay, r_down, r_reps, r_last} = rdata;

    chirp_profile_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (PW)
    ) u_ram (
        .clk   (clk),
        .we    (cfg_we),
        .waddr (cfg_addr),
        .wdata (wdata),
        .raddr (rd_idx),
        .rdata (rdata)
    );

    assign slot_last = last_q || (cur_idx == AW'(DEPTH - 1));
    assign end_evt   = is_down ? (nco_ctrl <= min_ctrl) : (nco_ctrl >= max_ctrl);
    assign reps_eff  = (reps_q == '0) ? RPT_W'(1) : reps_q;
    assign rep_hit   = (rep_cnt + RPT_W'(1)) == reps_eff;

    // Read address is always the slot the next load would take.
    always_comb begin
        rd_idx = cur_idx + AW'(1);
        if (state == StIdle || slot_last) begin
            rd_idx = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            chirp_rst <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            cur_idx   <= '0;
            min_ctrl  <= '0;
            max_ctrl  <= '0;
            inc_rate  <= '0;
            div_rate  <= '0;
            delay     <= '0;
            is_down   <= 1'b0;
            rep_cnt   <= '0;
            reps_q    <= '0;
            last_q    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state     <= StIdle;
                chirp_rst <= 1'b1;
                busy      <= 1'b0;
            end else begin
                unique case (state)
                    StIdle: begin
                        if (start) begin
                            state     <= StLoad;
                            busy      <= 1'b1;
                            chirp_rst <= 1'b1;
                            cur_idx   <= rd_idx;
                            min_ctrl  <= r_min;
                            max_ctrl  <= r_max;
                            inc_rate  <= r_inc;
                            div_rate  <= r_div;
                            delay     <= r_delay;
                            is_down   <= r_down;
                            reps_q    <= r_reps;
                            last_q    <= r_last;
                        end
                    end
                    StLoad: begin
                        state     <= StPrime;
                        chirp_rst <= 1'b0;
                        rep_cnt   <= '0;
                    end
                    StPrime: begin
                        // First completion only moves Chirp from 0 onto its start word.
                        if (end_evt) begin
                            state <= StRun;
                        end
                    end
                    StRun: begin
                        if (end_evt) begin
                            rep_cnt <= rep_cnt + RPT_W'(1);
                            if (rep_hit) begin
                                chirp_rst <= 1'b1;
                                if (!slot_last || loop_en) begin
                                    state    <= StLoad;
                                    cur_idx  <= rd_idx;
                                    min_ctrl <= r_min;
                                    max_ctrl <= r_max;
                                    inc_rate <= r_inc;
                                    div_rate <= r_div;
                                    delay    <= r_delay;
                                    is_down  <= r_down;
                                    reps_q   <= r_reps;
                                    last_q   <= r_last;
                                end else begin
                                    state <= StIdle;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_chirp_sequencer.sv
// Bench for chirp_sequencer with a behavioural Chirp NCO; expected outputs come from
// per-slot durations computed arithmetically from the profile table.
module tb_chirp_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [31:0] cfg_min = '0, cfg_max = '0, cfg_inc = '0, cfg_div = '0;
    logic [3:0]  cfg_delay = '0;
    logic        cfg_down = 1'b0;
    logic [7:0]  cfg_reps = '0;
    logic        cfg_last = 1'b0;
    logic        start = 1'b0, stop = 1'b0, loop_en = 1'b0;
    logic [31:0] nco_ctrl;
    logic        chirp_rst;
    logic [31:0] min_ctrl, max_ctrl, inc_rate, div_rate;
    logic [3:0]  delay;
    logic        is_down, busy, done;
    logic [2:0]  cur_idx;

    chirp_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_min   (cfg_min),
        .cfg_max   (cfg_max),
        .cfg_inc   (cfg_inc),
        .cfg_div   (cfg_div),
        .cfg_delay (cfg_delay),
        .cfg_down  (cfg_down),
        .cfg_reps  (cfg_reps),
        .cfg_last  (cfg_last),
        .start     (start),
        .stop      (stop),
        .loop_en   (loop_en),
        .nco_ctrl  (nco_ctrl),
        .chirp_rst (chirp_rst),
        .min_ctrl  (min_ctrl),
        .max_ctrl  (max_ctrl),
        .inc_rate  (inc_rate),
        .div_rate  (div_rate),
        .delay     (delay),
        .is_down   (is_down),
        .busy      (busy),
        .done      (done),
        .cur_idx   (cur_idx)
    );

    always #5 clk = ~clk;

    // Behavioural Chirp: one step per cycle, wrap to the start word at the end word.
    logic [31:0] nco;
    always_ff @(posedge clk) begin
        if (chirp_rst) nco <= '0;
        else if (is_down) nco <= (nco <= min_ctrl) ? max_ctrl : nco - inc_rate;
        else nco <= (nco >= max_ctrl) ? min_ctrl : nco + inc_rate;
    end
    assign nco_ctrl = nco;

    typedef struct packed { logic busy; logic crst; logic done; } exp_t;
    localparam exp_t E_IDLE = '{busy: 1'b0, crst: 1'b1, done: 1'b0};
    localparam exp_t E_DONE = '{busy: 1'b0, crst: 1'b1, done: 1'b1};
    localparam exp_t E_LOAD = '{busy: 1'b1, crst: 1'b1, done: 1'b0};
    localparam exp_t E_PLAY = '{busy: 1'b1, crst: 1'b0, done: 1'b0};

    exp_t q[$];
    int unsigned m_min[8], m_max[8], m_inc[8], m_delay[8], m_down[8], m_reps[8], m_last[8];
    int unsigned e_idx, e_min, e_max, e_inc, e_delay, e_down;
    bit          m_active, s_last;
    int          ld[8];
    int          nvec = 0, nerr = 0;
    bit          pend = 0;
    int unsigned p_addr, p_min, p_max, p_inc, p_delay, p_down, p_reps, p_last;

    function automatic int unsigned cdiv(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Append the expected cycles of one slot: LOAD, the priming sweep, reps full sweeps.
    task automatic gen_slot(input int unsigned idx);
        int unsigned p, t, r;
        e_idx = idx; e_min = m_min[idx]; e_max = m_max[idx]; e_inc = m_inc[idx];
        e_delay = m_delay[idx]; e_down = m_down[idx];
        s_last = (m_last[idx] != 0) || (idx == 7);
        r = (m_reps[idx] == 0) ? 1 : m_reps[idx];
        p = e_down ? 1 : cdiv(e_max, e_inc) + 1;
        t = (e_max > e_min) ? cdiv(e_max - e_min, e_inc) + 1 : 1;
        ld[idx]++;
        q.push_back(E_LOAD);
        repeat (p + r * t) q.push_back(E_PLAY);
    endtask

    task automatic step();
        exp_t cur;
        @(posedge clk);
        cur = q.pop_front();
        if (rst) begin
            q.delete(); m_active = 0;
            e_idx = 0; e_min = 0; e_max = 0; e_inc = 0; e_delay = 0; e_down = 0;
        end else if (stop) begin
            q.delete(); m_active = 0;
        end else if (start && !cur.busy) begin
            q.delete(); gen_slot(0); m_active = 1;
        end
        if (q.size() == 0) begin
            if (m_active) begin
                if (!s_last) gen_slot(e_idx + 1);
                else if (loop_en) gen_slot(0);
                else begin q.push_back(E_DONE); m_active = 0; end
            end else q.push_back(E_IDLE);
        end
        if (pend) begin
            m_min[p_addr] = p_min; m_max[p_addr] = p_max; m_inc[p_addr] = p_inc;
            m_delay[p_addr] = p_delay; m_down[p_addr] = p_down;
            m_reps[p_addr] = p_reps; m_last[p_addr] = p_last;
            pend = 0;
        end
        #1;
        chk("busy", 32'(busy), 32'(q[0].busy));
        chk("chirp_rst", 32'(chirp_rst), 32'(q[0].crst));
        chk("done", 32'(done), 32'(q[0].done));
        chk("cur_idx", 32'(cur_idx), e_idx);
        chk("min_ctrl", min_ctrl, e_min);
        chk("max_ctrl", max_ctrl, e_max);
        chk("inc_rate", inc_rate, e_inc);
        chk("div_rate", div_rate, 32'd0);
        chk("delay", 32'(delay), e_delay);
        chk("is_down", 32'(is_down), e_down);
    endtask

    task automatic write_slot(input int unsigned a, input int unsigned mn, input int unsigned mx,
                              input int unsigned inc, input int unsigned dly,
                              input int unsigned dn, input int unsigned reps,
                              input int unsigned last);
        cfg_we = 1'b1; cfg_addr = 3'(a); cfg_min = mn; cfg_max = mx; cfg_inc = inc;
        cfg_div = '0; cfg_delay = 4'(dly); cfg_down = dn[0]; cfg_reps = 8'(reps);
        cfg_last = last[0];
        p_addr = a; p_min = mn; p_max = mx; p_inc = inc; p_delay = dly & 15;
        p_down = dn & 1; p_reps = reps & 255; p_last = last & 1; pend = 1;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; step(); stop = 1'b0;
    endtask

    task automatic run_idle(input int budget);
        int n = 0;
        while (m_active && n < budget) begin step(); n++; end
        chk("sequence_timeout", 32'(m_active), 32'd0);
        repeat (3) step();
    endtask

    task automatic clear_ld();
        for (int i = 0; i < 8; i++) ld[i] = 0;
    endtask

    task automatic rand_table();
        for (int i = 0; i < 8; i++) begin
            int unsigned inc;
            inc = 1 + $urandom % 16;
            write_slot(i, inc + $urandom % 64, $urandom % 128, inc, $urandom % 16,
                       $urandom % 2, $urandom % 4, ($urandom % 4) == 0);
        end
    endtask

    initial begin
        q.push_back(E_IDLE);
        m_active = 0; s_last = 0; clear_ld();
        for (int i = 0; i < 8; i++) begin
            m_min[i] = 0; m_max[i] = 0; m_inc[i] = 1; m_delay[i] = 0;
            m_down[i] = 0; m_reps[i] = 1; m_last[i] = 1;
        end
        repeat (3) step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) write_slot(i, 0, 0, 1, 0, 0, 1, 1);
        repeat (2) step();

        // Single up slot, two counted sweeps
        write_slot(0, 'h100, 'h200, 'h10, 3, 0, 2, 1);
        pulse_start();
        run_idle(2000);

        // Up slot then down slot
        write_slot(0, 'h100, 'h200, 'h10, 1, 0, 1, 0);
        write_slot(1, 'h40, 'h80, 4, 2, 1, 3, 1);
        pulse_start();
        run_idle(2000);

        // Same pair looping three times, then stop
        loop_en = 1'b1; clear_ld();
        pulse_start();
        for (int n = 0; n < 5000 && ld[0] < 4; n++) step();
        chk("loop_count", 32'(ld[0]), 32'd4);
        pulse_stop();
        repeat (3) step();
        loop_en = 1'b0;

        // Stop in PRIME, stop in RUN, then a clean restart
        pulse_start();
        repeat (3) step();
        pulse_stop();
        repeat (2) step();
        pulse_start();
        repeat (40) step();
        pulse_stop();
        repeat (2) step();
        pulse_start();
        repeat (5) step();
        pulse_start();
        run_idle(2000);

        // Rewrite the playing slot while looping
        write_slot(0, 'h10, 'h20, 4, 0, 0, 1, 0);
        write_slot(1, 'h40, 'h80, 4, 5, 1, 1, 0);
        write_slot(2, 'h100, 'h200, 'h20, 7, 0, 2, 1);
        loop_en = 1'b1; clear_ld();
        pulse_start();
        for (int n = 0; n < 3000 && ld[2] < 1; n++) step();
        repeat (10) step();
        write_slot(2, 'h100, 'h300, 'h20, 9, 0, 2, 1);
        for (int n = 0; n < 5000 && ld[0] < 3; n++) step();
        chk("rewrite_reload", 32'(ld[2]), 32'd2);
        pulse_stop();
        repeat (2) step();
        loop_en = 1'b0;

        // start and stop together stay idle
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        repeat (3) step();

        // reps = 0 plays one chirp
        write_slot(0, 'h20, 'h60, 8, 0, 0, 0, 1);
        pulse_start();
        run_idle(2000);

        // All eight slots without a last flag; done pulse followed by immediate start
        for (int i = 0; i < 8; i++) write_slot(i, 8 + i, 24 + 2 * i, 2, i, i % 2, 1 + i % 3, 0);
        pulse_start();
        for (int n = 0; n < 5000 && q[0] != E_DONE; n++) step();
        pulse_start();
        run_idle(5000);

        // Randomized tables, plus a reset mid-sequence that keeps the table
        for (int it = 0; it < 3; it++) begin
            rand_table();
            loop_en = 1'b0;
            pulse_start();
            if (it == 1) begin
                repeat (50 + $urandom % 100) step();
                rst = 1'b1; step(); rst = 1'b0;
                repeat (2) step();
                pulse_start();
            end
            run_idle(20000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
